// File: rtl/dmem_pkg.sv
// Shared types and widths for the multi-cycle data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} dmem_state_t;

  localparam int DMEM_CNT_W  = 4;
  localparam int DMEM_WORD_W = 32;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data storage: synchronous write, synchronous read into a
// resettable output register that can also be cleared on a completed write.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic                   clr,
  input  logic [ADDR_BITS-1:0]   addr,
  input  logic [DMEM_WORD_W-1:0] wdata,
  output logic [DMEM_WORD_W-1:0] rdata
);

  // Storage itself is deliberately not reset.
  logic [DMEM_WORD_W-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[addr];
    end else if (clr) begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's data port: freezes the pipeline via
// Mem_state for LATENCY+1 cycles per access, then presents registered RData.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY   = 3,
  parameter int ADDR_BITS = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MemRead,
  input  logic                   MemWrite,
  input  logic [31:0]            Addr,
  input  logic [DMEM_WORD_W-1:0] WData,
  output logic [DMEM_WORD_W-1:0] RData,
  output logic                   Mem_state
);

  localparam logic [DMEM_CNT_W-1:0] CNT_LOAD = DMEM_CNT_W'(LATENCY - 1);

  dmem_state_t           state, state_next;
  logic [DMEM_CNT_W-1:0] cnt, cnt_next;
  logic                  is_write, is_write_next;
  logic                  req;
  logic                  wr_en, rd_en, clr;
  logic [ADDR_BITS-1:0]  word_addr;
  logic                  unused_addr_bits;

  assign req              = MemRead | MemWrite;
  assign word_addr        = Addr[ADDR_BITS+1:2];
  assign unused_addr_bits = ^{Addr[31:ADDR_BITS+2], Addr[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      is_write <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      is_write <= is_write_next;
    end
  end

  // Mem_state must drop combinationally in the very cycle a request appears.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    is_write_next = is_write;
    wr_en         = 1'b0;
    rd_en         = 1'b0;
    clr           = 1'b0;
    Mem_state     = 1'b1;
    case (state)
      IDLE: begin
        if (req) begin
          Mem_state     = 1'b0;
          state_next    = ACCESS;
          cnt_next      = CNT_LOAD;
          is_write_next = MemWrite;
        end
      end
      ACCESS: begin
        Mem_state = 1'b0;
        if (!req) begin
          state_next = IDLE;
        end else if (cnt == '0) begin
          state_next = DONE;
          wr_en      = is_write;
          clr        = is_write;
          rd_en      = !is_write;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  dmem_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .clr   (clr),
    .addr  (word_addr),
    .wdata (WData),
    .rdata (RData)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed scenarios plus random
// reads/writes checked against an associative-array memory model.
module tb_dmem_responder;

  localparam int LATENCY   = 3;
  localparam int ADDR_BITS = 10;
  localparam int WORDS     = 1 << ADDR_BITS;

  typedef struct {
    logic [31:0] rdata;
    int          freeze;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite;
  logic [31:0] Addr, WData;
  logic [31:0] RData;
  logic        Mem_state;

  exp_t        sb_q[$];
  logic [31:0] model [int];
  int          written_q[$];
  logic [31:0] last_rdata = 32'h0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          freeze_cnt = 0;

  dmem_responder #(
    .LATENCY   (LATENCY),
    .ADDR_BITS (ADDR_BITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .WData     (WData),
    .RData     (RData),
    .Mem_state (Mem_state)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts frozen cycles of a request and scores it when it completes.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      freeze_cnt = 0;
    end else if ((MemRead || MemWrite) && !Mem_state) begin
      freeze_cnt++;
    end else if ((MemRead || MemWrite) && Mem_state && freeze_cnt > 0) begin
      if (sb_q.size() == 0) begin
        check_output("unexpected_completion", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_output("done_rdata", RData, e.rdata);
        check_output("freeze_cycles", freeze_cnt, e.freeze);
        last_rdata = e.rdata;
      end
      freeze_cnt = 0;
      done_cnt++;
    end else begin
      freeze_cnt = 0;
    end
  end

  // Called just after a rising edge; returns just after the edge leaving DONE.
  task automatic apply_stimulus(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    int   idx;
    int   start;
    bit   seen;
    exp_t e;
    idx      = int'((a >> 2) % WORDS);
    MemRead  = rd;
    MemWrite = wr;
    Addr     = a;
    WData    = wd;
    if (wr) begin
      model[idx] = wd;
      written_q.push_back(idx);
      e.rdata = 32'h0;
    end else begin
      e.rdata = model[idx];
    end
    e.freeze = LATENCY + 1;
    sb_q.push_back(e);
    start = done_cnt;
    seen  = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(posedge clk);
      if (done_cnt != start) seen = 1'b1;
    end
    if (!seen) begin
      check_output("access_timeout", 32'd0, 32'd1);
      void'(sb_q.pop_back());
    end
    #1;
  endtask

  task automatic idle_cycles(input int n);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_output("idle_ready", Mem_state, 1'b1);
      check_output("idle_rdata_hold", RData, last_rdata);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Addr     = 32'h0;
    WData    = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_output("reset_rdata", RData, 32'h0);
      check_output("reset_ready", Mem_state, 1'b1);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    idle_cycles(2);

    apply_stimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0);
    idle_cycles(1);

    // Back-to-back with aliasing: 0x1000 and 0x0000 hit the same word.
    apply_stimulus(1'b0, 1'b1, 32'h1000, 32'h12345678);
    apply_stimulus(1'b1, 1'b0, 32'h0000, 32'h0);

    apply_stimulus(1'b1, 1'b1, 32'h20, 32'hA5A5A5A5);
    apply_stimulus(1'b1, 1'b0, 32'h20, 32'h0);

    apply_stimulus(1'b0, 1'b1, 32'h30, 32'h11111111);
    MemRead  = 1'b0;
    MemWrite = 1'b1;
    Addr     = 32'h30;
    WData    = 32'h22222222;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("rst_mid_rdata", RData, 32'h0);
    MemWrite = 1'b0;
    #1;
    check_output("rst_mid_ready", Mem_state, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    last_rdata = 32'h0;
    apply_stimulus(1'b1, 1'b0, 32'h30, 32'h0);

    MemRead = 1'b1;
    Addr    = 32'h40;
    @(posedge clk);
    #1 MemRead = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_output("abort_ready", Mem_state, 1'b1);
    check_output("abort_rdata", RData, last_rdata);
    @(posedge clk);
    #1;

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int          idx;
      if (written_q.size() == 0 || ($urandom % 2) == 0) begin
        idx = $urandom_range(0, 15);
        a   = ($urandom & 32'hFFFF_F000) | (idx << 2) | ($urandom & 32'h3);
        apply_stimulus(1'($urandom % 2), 1'b1, a, $urandom);
      end else begin
        idx = written_q[$urandom_range(0, written_q.size() - 1)];
        a   = ($urandom & 32'hFFFF_F000) | (idx << 2) | ($urandom & 32'h3);
        apply_stimulus(1'b1, 1'b0, a, $urandom);
      end
      idle_cycles($urandom_range(0, 2));
    end

    idle_cycles(2);
    check_output("scoreboard_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the pipelined MIPS core: the memory-side end of the core's external data-memory interface. Accepts the core's read/write strobes, word address and write data from EX/MEM, holds the pipeline frozen via `Mem_state` while the access is in flight, then returns read data for capture into MEM/WB. Sits outside the core, beside the instruction memory, and replaces the zero-latency data memory.

## Interface
Parameters:
- `LATENCY`, 3: cycles spent in ACCESS per request; legal range 1..15.
- `ADDR_BITS`, 10: word-address width; the array holds 2^ADDR_BITS 32-bit words.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `MemRead`  in  1  read request from the core (EX/MEM stage).
- `MemWrite`  in  1  write request from the core (EX/MEM stage).
- `Addr`  in  32  byte address (core ALU result); `Addr[ADDR_BITS+1:2]` is used, other bits ignored.
- `WData`  in  32  write data.
- `RData`  out  32  registered read data.
- `Mem_state`  out  1  1 = ready/pipeline may advance, 0 = freeze pipeline.

## Operation
- `req = MemRead | MemWrite`; a write is any request with `MemWrite = 1`. Simultaneous `MemRead` and `MemWrite` is treated as a write.
- States: IDLE, ACCESS, DONE.
- IDLE: if `req`, load the counter with `LATENCY-1`, latch the write flag, and go to ACCESS. Otherwise stay in IDLE.
- ACCESS: decrement the counter each cycle. When the counter equals 0, go to DONE:
  - read: load `RData` from `array[Addr word]`.
  - write: store `WData` into the array; `RData` is set to 0.
- DONE: go to IDLE unconditionally; the core advances on this edge. A request seen in the following IDLE cycle is a new access, including back-to-back accesses to the same address.
- `Mem_state` is combinational: 0 when (IDLE and `req`) or ACCESS; 1 in DONE and in IDLE without `req`. It must drop in the same cycle a request first appears so the core freezes immediately.
- Protocol violation: if `req` falls during ACCESS, abort to IDLE, commit no write, and leave `RData` unchanged.
- Address wrap: addresses beyond the array alias modulo 2^ADDR_BITS words.
- The array is not reset. Read-before-write contents are undefined to the core; the bench must write first.

## Timing
- Reset (asynchronous, `rst = 0`): state goes to IDLE, counter to 0, `RData` to 0, and `Mem_state` evaluates to 1 when `req = 0`. Reset mid-ACCESS aborts the access with no array write.
- A request first seen in cycle T:
  - `Mem_state` is 0 during cycles T..T+LATENCY.
  - DONE is in cycle T+LATENCY+1, with `Mem_state = 1` and `RData` valid.
  - Total freeze is LATENCY+1 cycles.
- `Addr`, `WData`, `MemRead` and `MemWrite` must stay stable from T through DONE. The frozen EX/MEM register guarantees this.
- `RData` holds its value until the next completed access.
- No bypass from a pending write: a read issued after a write completes always observes the written value.

## Structure
- Shared package `dmem_pkg`:
  - state enum `dmem_state_t` {IDLE, ACCESS, DONE}
  - `DMEM_CNT_W = 4`
  - `DMEM_WORD_W = 32`
- One sub-module, `dmem_array`: 2^ADDR_BITS x 32 storage with synchronous write enable and synchronous read into a register. The FSM, counter and `Mem_state` logic live in the top level.

## Test plan
- Reset then idle: `rst` low for 2 cycles, then high, no request → `RData = 0`, `Mem_state = 1` every cycle.
- Write then read, `LATENCY = 3`: write `Addr = 0x10`, `WData = 0xDEADBEEF` → `Mem_state` 0 for 4 cycles, 1 in DONE. Then read `0x10` → `RData = 0xDEADBEEF` in DONE, 4-cycle freeze.
- Back-to-back and wrap, `ADDR_BITS = 10`: write `0x1000` with `0x12345678`, immediately followed by a read of `0x0000` → the second request restarts the FSM from IDLE and `RData = 0x12345678` (alias).
- Simultaneous strobes: `MemRead = MemWrite = 1`, `Addr = 0x20`, `WData = 0xA5A5A5A5` → treated as a write, `RData = 0`; a later read of `0x20` returns `0xA5A5A5A5`.
- Reset mid-access: write `0x30` / `0x11111111` completes; then a write of `0x30` / `0x22222222` with `rst` pulsed low in the 2nd ACCESS cycle → state returns to IDLE, `RData = 0`; a re-read of `0x30` returns `0x11111111`.
- Request drop: raise `MemRead` at `0x40`, drop it in ACCESS → return to IDLE, `RData` unchanged, `Mem_state = 1` the next cycle.
